// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, runs a req/ack program-memory read on the
// control unit's fetch state, and resolves conditional jumps on its jump state.
module fetch_unit #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int RESET_PC = 0,
  parameter int WAIT_MAX = 15,
  parameter logic [3:0] ST_FETCH_PC = 4'd1,
  parameter logic [3:0] ST_JMP      = 4'd7,
  parameter logic [4:0] OP_JMP = 5'h0C,
  parameter logic [4:0] OP_JZ  = 5'h0D,
  parameter logic [4:0] OP_JNZ = 5'h0E,
  parameter logic [4:0] OP_JC  = 5'h0F,
  parameter logic [4:0] OP_JNC = 5'h10
) (
  input  logic              clk,
  input  logic              reset_cycle,
  input  logic [3:0]        state,
  input  logic [4:0]        opcode,
  input  logic              zero_flag,
  input  logic              carry_flag,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instruction,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_valid,
  output logic              jump_taken,
  output logic              busy,
  output logic              fetch_err
);

  localparam logic [ADDR_W-1:0] LP_RESET_PC = ADDR_W'(RESET_PC);
  localparam logic [7:0]        LP_WAIT_MAX = 8'(WAIT_MAX);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ERR} fsm_t;

  fsm_t              r_fsm, w_fsm_nxt;
  logic [7:0]        r_wait_cnt, w_wait_cnt_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [DATA_W-1:0] r_instr, w_instr_nxt;
  logic              r_mem_req, w_mem_req_nxt;
  logic              r_fetch_valid, w_fetch_valid_nxt;
  logic              r_jump_taken, w_jump_taken_nxt;
  logic              r_fetch_err, w_fetch_err_nxt;
  logic              w_taken;
  logic              w_timeout;

  always_comb begin
    case (opcode)
      OP_JMP:  w_taken = 1'b1;
      OP_JZ:   w_taken = zero_flag;
      OP_JNZ:  w_taken = ~zero_flag;
      OP_JC:   w_taken = carry_flag;
      OP_JNC:  w_taken = ~carry_flag;
      default: w_taken = 1'b0;
    endcase
  end

  // Count reaches WAIT_MAX on the edge that would be the WAIT_MAX-th miss.
  assign w_timeout = ((r_wait_cnt + 8'd1) == LP_WAIT_MAX);

  always_ff @(posedge clk or posedge reset_cycle) begin
    if (reset_cycle) r_fsm <= S_IDLE;
    else             r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      S_IDLE:  if (state == ST_FETCH_PC) w_fsm_nxt = S_REQ;
      S_REQ: begin
        if (mem_ack)        w_fsm_nxt = S_IDLE;
        else if (w_timeout) w_fsm_nxt = S_ERR;
      end
      S_ERR:   w_fsm_nxt = S_ERR;
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_pc_nxt          = r_pc;
    w_mem_addr_nxt    = r_mem_addr;
    w_instr_nxt       = r_instr;
    w_mem_req_nxt     = r_mem_req;
    w_fetch_err_nxt   = r_fetch_err;
    w_wait_cnt_nxt    = r_wait_cnt;
    w_fetch_valid_nxt = 1'b0;
    w_jump_taken_nxt  = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        if (state == ST_FETCH_PC) begin
          w_mem_addr_nxt = r_pc;
          w_mem_req_nxt  = 1'b1;
          w_wait_cnt_nxt = 8'd0;
        end else if ((state == ST_JMP) && w_taken) begin
          w_pc_nxt         = r_instr[ADDR_W-1:0];
          w_jump_taken_nxt = 1'b1;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          w_instr_nxt       = mem_rdata;
          w_pc_nxt          = r_pc + ADDR_W'(1);
          w_mem_req_nxt     = 1'b0;
          w_fetch_valid_nxt = 1'b1;
        end else if (w_timeout) begin
          w_mem_req_nxt   = 1'b0;
          w_fetch_err_nxt = 1'b1;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset_cycle) begin
    if (reset_cycle) begin
      r_pc          <= LP_RESET_PC;
      r_mem_addr    <= '0;
      r_instr       <= '0;
      r_mem_req     <= 1'b0;
      r_fetch_valid <= 1'b0;
      r_jump_taken  <= 1'b0;
      r_fetch_err   <= 1'b0;
      r_wait_cnt    <= 8'd0;
    end else begin
      r_pc          <= w_pc_nxt;
      r_mem_addr    <= w_mem_addr_nxt;
      r_instr       <= w_instr_nxt;
      r_mem_req     <= w_mem_req_nxt;
      r_fetch_valid <= w_fetch_valid_nxt;
      r_jump_taken  <= w_jump_taken_nxt;
      r_fetch_err   <= w_fetch_err_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
    end
  end

  assign pc          = r_pc;
  assign mem_addr    = r_mem_addr;
  assign instruction = r_instr;
  assign mem_req     = r_mem_req;
  assign fetch_valid = r_fetch_valid;
  assign jump_taken  = r_jump_taken;
  assign fetch_err   = r_fetch_err;
  assign busy        = (r_fsm == S_REQ);

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the control unit. It owns the program counter, runs a request/acknowledge read of program memory when the control unit signals the fetch state, and holds the fetched word in the instruction register that drives the control unit's `instruction` input. It also resolves conditional jumps by loading the PC from the instruction's target field when the control unit signals the jump state.

## Interface
- `ADDR_W`, 8: program counter / memory address width.
- `DATA_W`, 16: instruction width.
- `RESET_PC`, 0: PC value after reset.
- `WAIT_MAX`, 15: max unacknowledged request cycles before error (1..255).
- `ST_FETCH_PC`, 4'd1: state code that starts a fetch.
- `ST_JMP`, 4'd7: state code that evaluates a jump.
- `OP_JMP`/`OP_JZ`/`OP_JNZ`/`OP_JC`/`OP_JNC`, 5'h0C/0D/0E/0F/10: jump opcodes.

- `clk`  in  1  clock; all state changes on rising edge.
- `reset_cycle`  in  1  reset, asynchronous, active-high.
- `state`  in  4  current control-unit state.
- `opcode`  in  5  current opcode (equals `instruction[15:11]`).
- `zero_flag`  in  1  ALU zero flag.
- `carry_flag`  in  1  ALU carry flag.
- `mem_addr`  out  ADDR_W  program memory read address.
- `mem_req`  out  1  read request, level, held until ack.
- `mem_ack`  in  1  memory has valid `mem_rdata` this cycle.
- `mem_rdata`  in  DATA_W  read data.
- `instruction`  out  DATA_W  instruction register.
- `pc`  out  ADDR_W  program counter.
- `fetch_valid`  out  1  one-cycle pulse: `instruction` just updated.
- `jump_taken`  out  1  one-cycle pulse: PC loaded from jump target.
- `busy`  out  1  fetch outstanding (FSM in REQ).
- `fetch_err`  out  1  sticky: request timed out.

## Operation
- FSM states: IDLE, REQ, ERR.
- IDLE, `state==ST_FETCH_PC`: `mem_addr<=pc`, `mem_req<=1`, wait counter cleared, go to REQ.
- IDLE, `state==ST_JMP`: evaluate taken = JMP, or JZ&zero, or JNZ&~zero, or JC&carry, or JNC&~carry. Any other opcode is not taken. If taken: `pc<=instruction[ADDR_W-1:0]`, `jump_taken` pulses. If not taken: PC unchanged.
- REQ, `mem_ack=1`: `instruction<=mem_rdata`, `pc<=pc+1` (mod 2^ADDR_W, so 0xFF wraps to 0x00), `mem_req<=0`, `fetch_valid` pulses, go to IDLE.
- REQ, `mem_ack=0`: counter increments. When the count reaches `WAIT_MAX`: `mem_req<=0`, `fetch_err<=1`, go to ERR. `instruction` and `pc` are unchanged.
- ERR: all `state` inputs are ignored. Only reset exits ERR.
- Any `state` input while in REQ (including a second ST_FETCH_PC or ST_JMP) is ignored. It is not queued.
- `mem_ack` seen in IDLE or ERR is ignored.
- `busy` = (FSM==REQ).
- Reset (asynchronous, takes effect at any time, including mid-REQ): `pc=RESET_PC`, `instruction=0`, `mem_addr=0`, `mem_req=0`, `fetch_valid=0`, `jump_taken=0`, `fetch_err=0`, counter=0, FSM=IDLE. A memory ack arriving after reset is released is ignored.

## Timing
- Edge E0 samples `state==ST_FETCH_PC` in IDLE. From E0, `mem_req=1` and `mem_addr` = old PC.
- The earliest ack is sampled at E1. After E1, `instruction` and `pc` are updated, `fetch_valid=1` for exactly one cycle, and `mem_req=0`. Minimum fetch latency is therefore 2 edges.
- `mem_addr` is stable for the whole time `mem_req` is high.
- Timeout: with no ack, `fetch_err` rises after edge E0+`WAIT_MAX`, and `mem_req` drops at the same edge.
- Jump: decided at the edge that samples `ST_JMP`. The new PC is visible after that edge, so the following ST_FETCH_PC uses the target.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Basic fetch: reset, memory[0]=16'h1234, ack delayed 3 cycles, pulse ST_FETCH_PC -> `mem_req` high for 4 cycles at `mem_addr=0`; then `instruction=16'h1234`, `pc=1`, one `fetch_valid` pulse.
- Jumps: `instruction[7:0]=8'h40`, opcode JZ, zero=1, ST_JMP -> `pc=8'h40`, `jump_taken` pulses. Same with zero=0 -> PC unchanged, no pulse. Repeat for JNZ/JC/JNC/JMP and for a non-jump opcode (never taken).
- PC wrap: `RESET_PC=8'hFF`, fetch with immediate ack -> `pc=8'h00`, `mem_addr` was `8'hFF`.
- Timeout: `WAIT_MAX=15`, never ack -> `fetch_err=1` after edge 15, `mem_req=0`, PC unchanged. Further ST_FETCH_PC ignored until reset clears `fetch_err`.
- Reset mid-request: assert `reset_cycle` between clock edges during REQ -> `mem_req` drops immediately and `pc=RESET_PC`. A later stray ack does not change `instruction`.
- Ignored inputs: a second ST_FETCH_PC and an ST_JMP while busy -> exactly one `mem_req` episode and no PC change beyond +1.
